// File: rtl/conv_window_gen.sv
// Streaming 5x5 window generator. It takes a raster-order Float8 pixel stream
// and emits one 200-bit window for every valid stride-1 position.
// Byte i of win_out is element (i/5, i%5) of the window. Byte 0 is the
// top-left pixel and byte 24 is the pixel accepted most recently.
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic [199:0] win_out,
    output logic         win_valid,
    input  logic         win_ready,
    output logic [5:0]   win_row,
    output logic [5:0]   win_col,
    output logic         frame_done
);
    localparam logic [5:0] COL_LAST = 6'(IMG_W - 1);
    localparam logic [5:0] ROW_LAST = 6'(IMG_H - 1);

    // Raster position of the next pixel to be accepted.
    logic [5:0] col_q, col_d;
    logic [5:0] row_q, row_d;

    // lb_q[0] holds row r-1 and lb_q[3] holds row r-4. Each buffer is
    // addressed directly by the 6-bit column counter.
    logic [7:0] lb_q [4][64];

    // 5x5 shift window, indexed [window row][window column].
    logic [7:0] win_q [5][5];
    logic [7:0] win_d [5][5];
    logic [7:0] new_col [5];

    logic       accept;
    logic       produce;
    logic       last_pix;
    logic       win_valid_q, win_valid_d;
    logic       frame_done_q, frame_done_d;
    logic [5:0] win_row_q, win_row_d;
    logic [5:0] win_col_q, win_col_d;

    // Accept a new pixel whenever no window is stalled at the output.
    assign pix_ready = !win_valid_q || win_ready;

    // Decode the current accept and assemble the column that enters the window.
    always_comb begin
        accept     = pix_valid && pix_ready;
        last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);
        produce    = accept && (row_q >= 6'd4) && (col_q >= 6'd4);
        new_col[0] = lb_q[3][col_q];
        new_col[1] = lb_q[2][col_q];
        new_col[2] = lb_q[1][col_q];
        new_col[3] = lb_q[0][col_q];
        new_col[4] = pix_in;
    end

    // Next state for the counters, the shift window and the output handshake.
    always_comb begin
        // NOTE: every variable gets a default first. This keeps the block free of latches.
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = accept && last_pix;

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = 6'd0;
                row_d = last_pix ? 6'd0 : row_q + 6'd1;
            end else begin
                col_d = col_q + 6'd1;
            end
            // At a column wrap the window is not flushed. Windows for c<4
            // are suppressed, so bytes from two rows never appear together.
            for (int wr = 0; wr < 5; wr++) begin
                for (int wc = 0; wc < 4; wc++) begin
                    win_d[wr][wc] = win_q[wr][wc + 1];
                end
                win_d[wr][4] = new_col[wr];
            end
        end

        // A new window replaces a window consumed at the same edge.
        // This avoids a bubble between consecutive windows.
        if (produce) begin
            win_valid_d = 1'b1;
            win_row_d   = row_q - 6'd4;
            win_col_d   = col_q - 6'd4;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            col_q        <= 6'd0;
            row_q        <= 6'd0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_row_q    <= 6'd0;
            win_col_q    <= 6'd0;
            for (int wr = 0; wr < 5; wr++) begin
                for (int wc = 0; wc < 5; wc++) begin
                    win_q[wr][wc] <= 8'd0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_q        <= win_d;
        end
    end

    // On each accept, every line buffer passes its column down one row.
    always_ff @(posedge clk) begin
        // NOTE: the line buffers are never reset. A new frame overwrites four
        // full rows before any window reads them.
        if (accept) begin
            lb_q[0][col_q] <= pix_in;
            lb_q[1][col_q] <= lb_q[0][col_q];
            lb_q[2][col_q] <= lb_q[1][col_q];
            lb_q[3][col_q] <= lb_q[2][col_q];
        end
    end

    // Pack the window into the flat output bus.
    always_comb begin
        win_out = '0;
        for (int wr = 0; wr < 5; wr++) begin
            for (int wc = 0; wc < 5; wc++) begin
                win_out[8 * (5 * wr + wc) +: 8] = win_q[wr][wc];
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed testbench for conv_window_gen.
// It drives a 28x28 instance through several phases:
//   - ideal streaming;
//   - an output stall;
//   - random handshakes across two back-to-back frames;
//   - a reset in the middle of a frame.
// It also drives a 5x5 instance that produces a single window.
module tb_conv_window_gen;

    typedef struct {
        int r;
        int c;
        int f;
    } win_t;

    logic         clk;
    logic         rst;

    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [199:0] win_out;
    logic         win_valid;
    logic         win_ready;
    logic [5:0]   win_row;
    logic [5:0]   win_col;
    logic         frame_done;

    logic [7:0]   s_pix_in;
    logic         s_pix_valid;
    logic         s_pix_ready;
    logic [199:0] s_win_out;
    logic         s_win_valid;
    logic         s_win_ready;
    logic [5:0]   s_win_row;
    logic [5:0]   s_win_col;
    logic         s_frame_done;

    int checks = 0;
    int errors = 0;

    // Stream position and frame number of the next pixel the bench offers.
    int cur_r = 0;
    int cur_c = 0;
    int cur_f = 0;
    int fd_count = 0;
    int cnt [8];
    int off_tab [8];
    win_t q [$];

    conv_window_gen #(.IMG_W(28), .IMG_H(28)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    conv_window_gen #(.IMG_W(5), .IMG_H(5)) u_small (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (s_pix_in),
        .pix_valid  (s_pix_valid),
        .pix_ready  (s_pix_ready),
        .win_out    (s_win_out),
        .win_valid  (s_win_valid),
        .win_ready  (s_win_ready),
        .win_row    (s_win_row),
        .win_col    (s_win_col),
        .frame_done (s_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int r, input int c, input int f);
        return 8'(28 * r + c + off_tab[f]);
    endfunction

    function automatic logic [199:0] exp_win(input win_t w);
        logic [199:0] v;
        v = '0;
        for (int wr = 0; wr < 5; wr++) begin
            for (int wc = 0; wc < 5; wc++) begin
                v[8 * (5 * wr + wc) +: 8] = pix_val(w.r + wr, w.c + wc, w.f);
            end
        end
        return v;
    endfunction

    // One clock cycle on the 28x28 instance.
    // It is entered 1 time unit after a rising edge.
    task automatic cycle(input bit pv, input bit wr);
        bit   acc;
        bit   last;
        win_t w;
        pix_valid = pv;
        win_ready = wr;
        pix_in    = pix_val(cur_r, cur_c, cur_f);
        #1;
        check("pix_ready", pix_ready, (q.size() == 0) || wr);
        acc  = pv && ((q.size() == 0) || wr);
        last = (cur_r == 27) && (cur_c == 27);
        if ((q.size() != 0) && wr) begin
            w = q.pop_front();
            cnt[w.f]++;
            check("win_out", win_out, exp_win(w));
            check("win_row", win_row, w.r);
            check("win_col", win_col, w.c);
            if (w.f == 0 && w.r == 0 && w.c == 0) begin
                check("first_b0", win_out[7:0], 8'h00);
                check("first_b4", win_out[39:32], 8'h04);
                check("first_b20", win_out[167:160], 8'h70);
                check("first_b24", win_out[199:192], 8'h74);
            end
            if (w.f == 1 && w.r == 0 && w.c == 1)
                check("after_stall_b24", win_out[199:192], 8'h75);
            if (w.f == 0 && w.r == 1 && w.c == 0)
                check("row1_col0_b0", win_out[7:0], 8'h1C);
            if (w.f == 0 && w.r == 23 && w.c == 23) begin
                check("last_b24", win_out[199:192], 8'h0F);
                check("last_fd", frame_done, 1'b1);
            end
            if (w.f == 3 && w.r == 0 && w.c == 0)
                check("frame2_b0", win_out[7:0], 8'h40);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            if (cur_r >= 4 && cur_c >= 4) q.push_back('{cur_r - 4, cur_c - 4, cur_f});
            if (cur_c == 27) begin
                cur_c = 0;
                if (cur_r == 27) begin
                    cur_r = 0;
                    cur_f++;
                end else begin
                    cur_r++;
                end
            end else begin
                cur_c++;
            end
        end
        check("frame_done", frame_done, acc && last);
        check("win_valid", win_valid, q.size() != 0);
        if (frame_done) fd_count++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [199:0] stalled;
        logic [199:0] s_exp;
        int guard;

        for (int i = 0; i < 8; i++) begin
            cnt[i]     = 0;
            off_tab[i] = 0;
        end
        off_tab[3] = 8'h40;

        rst         = 1'b1;
        pix_valid   = 1'b0;
        win_ready   = 1'b0;
        pix_in      = 8'h00;
        s_pix_valid = 1'b0;
        s_win_ready = 1'b0;
        s_pix_in    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_win_out", win_out, '0);
        check("rst_win_row", win_row, 6'd0);
        check("rst_win_col", win_col, 6'd0);
        check("rst_pix_ready", pix_ready, 1'b1);
        check("rst_s_win_valid", s_win_valid, 1'b0);

        // Frame 0 streams with no stalls.
        guard = 0;
        while (cur_f < 1 && guard < 2000) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        check("ideal_progress", 32'(cur_f), 32'd1);

        // Frame 1 follows back-to-back. The output stalls for 10 cycles at
        // its first window.
        for (int i = 0; i < 117; i++) cycle(1'b1, 1'b1);
        check("stall_front_valid", win_valid, 1'b1);
        stalled = win_out;
        check("stall_first_win", stalled, exp_win('{0, 0, 1}));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            check("stall_win_hold", win_out, stalled);
            check("stall_row_hold", win_row, 6'd0);
            check("stall_col_hold", win_col, 6'd0);
        end
        guard = 0;
        while (cur_f < 2 && guard < 2000) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        check("stall_progress", 32'(cur_f), 32'd2);

        // Frames 2 and 3 run with random pix_valid and win_ready.
        guard = 0;
        while (cur_f < 4 && guard < 20000) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
        end
        check("random_progress", 32'(cur_f), 32'd4);

        // Frame 4 streams up to pixel (10,7). Reset is then asserted for one cycle.
        guard = 0;
        while (!(cur_r == 10 && cur_c == 8) && guard < 2000) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        rst       = 1'b1;
        pix_valid = 1'b1;
        win_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_win_valid", win_valid, 1'b0);
        check("midrst_frame_done", frame_done, 1'b0);
        check("midrst_win_out", win_out, '0);
        check("midrst_win_row", win_row, 6'd0);
        check("midrst_win_col", win_col, 6'd0);
        q.delete();
        cur_r = 0;
        cur_c = 0;
        cur_f = 5;

        // Frame 5 is the full re-streamed frame.
        guard = 0;
        while (cur_f < 6 && guard < 2000) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        guard = 0;
        while (q.size() != 0 && guard < 5) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);

        check("count_f0", 32'(cnt[0]), 32'd576);
        check("count_f1", 32'(cnt[1]), 32'd576);
        check("count_f2", 32'(cnt[2]), 32'd576);
        check("count_f3", 32'(cnt[3]), 32'd576);
        check("count_f5", 32'(cnt[5]), 32'd576);
        check("frame_done_count", 32'(fd_count), 32'd5);

        // The 5x5 instance produces exactly one window.
        for (int i = 0; i < 25; i++) begin
            s_pix_in    = 8'(i);
            s_pix_valid = 1'b1;
            s_win_ready = 1'b1;
            #1;
            check("s_pix_ready", s_pix_ready, 1'b1);
            @(posedge clk);
            #1;
            check("s_win_valid", s_win_valid, i == 24);
            check("s_frame_done", s_frame_done, i == 24);
        end
        s_pix_valid = 1'b0;
        s_exp = '0;
        for (int i = 0; i < 25; i++) s_exp[8 * i +: 8] = 8'(i);
        check("s_win_out", s_win_out, s_exp);
        check("s_win_row", s_win_row, 6'd0);
        check("s_win_col", s_win_col, 6'd0);
        @(posedge clk);
        #1;
        check("s_win_valid_after", s_win_valid, 1'b0);
        check("s_frame_done_after", s_frame_done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
